// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared widths, sentinel and scanner state encoding for the
//             FFT magnitude post-processing blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_BINS  = 1024;
    localparam int FFT_MAG_W = 16;
    localparam int FFT_BIN_W = 10;
    localparam int BUCKET_W  = 11;

    // Bucket index 0 is never a real candidate (DC), so it doubles as "no tone"
    localparam logic [BUCKET_W-1:0] NO_PEAK = 11'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } peak_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/bram_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : bram_read_pipe
//  Brief    : DEPTH-stage delay line of {valid, index} that tracks which BRAM
//             address the read data currently on the bus belongs to.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_read_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_index [DEPTH];

    // Shift the issued address tag along with the BRAM read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_index[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_index[0] <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_index[i] <= r_index[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_index = r_index[DEPTH-1];

endmodule : bram_read_pipe
`default_nettype wire

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_peak_finder
//  Brief    : Scans the FFT magnitude BRAM after each frame and reports the
//             lowest-indexed bin holding the largest magnitude, or 0 when the
//             peak is below the noise floor.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_peak_finder
    import fft_pkg::*;
#(
    parameter int              NUM_BINS     = 1024,
    parameter int              MIN_BIN      = 1,
    parameter logic [15:0]     NOISE_FLOOR  = 16'h0040,
    parameter int              READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FFT_MAG_W-1:0] cur_fft,
    output logic [FFT_BIN_W-1:0] read_addr,
    output logic                 read_enable,
    output logic [BUCKET_W-1:0]  largest_bucket,
    output logic [FFT_MAG_W-1:0] peak_mag,
    output logic                 done,
    output logic                 busy
);

    localparam logic [FFT_BIN_W-1:0] c_first_addr = FFT_BIN_W'(MIN_BIN);
    localparam logic [FFT_BIN_W-1:0] c_last_addr  = FFT_BIN_W'(NUM_BINS - 1);
    localparam logic [1:0]           c_drain_init = 2'(READ_LATENCY - 1);

    peak_state_t            r_state;
    peak_state_t            w_state_next;
    logic                   w_accept;
    logic                   w_last_issue;
    logic                   w_report;
    logic [1:0]             r_drain_cnt;
    logic [FFT_MAG_W-1:0]   r_max;
    logic [FFT_BIN_W-1:0]   r_idx;
    logic                   r_first;
    logic                   w_pipe_valid;
    logic [FFT_BIN_W-1:0]   w_pipe_index;

    bram_read_pipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (FFT_BIN_W)
    ) u_read_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (read_enable),
        .in_index  (read_addr),
        .out_valid (w_pipe_valid),
        .out_index (w_pipe_index)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; busy stays high through the done cycle, so a start
    // seen while the report is still being presented is ignored as well
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last_issue = 1'b0;
        w_report     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !busy) begin
                    w_accept     = 1'b1;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (read_addr == c_last_addr) begin
                    w_last_issue = 1'b1;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == 2'd0) begin
                    w_state_next = REPORT;
                end
            end
            REPORT: begin
                w_report     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Address sweep, running max tracking and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_addr      <= '0;
            read_enable    <= 1'b0;
            largest_bucket <= NO_PEAK;
            peak_mag       <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            r_drain_cnt    <= '0;
            r_max          <= '0;
            r_idx          <= '0;
            r_first        <= 1'b0;
        end else begin
            done <= 1'b0;

            // First sample is always taken so a flat spectrum reports MIN_BIN;
            // afterwards only a strictly larger value moves the index (ties
            // keep the lowest bin)
            if (w_pipe_valid) begin
                r_first <= 1'b0;
                if (r_first || (cur_fft > r_max)) begin
                    r_max <= cur_fft;
                    r_idx <= w_pipe_index;
                end
            end

            if (w_accept) begin
                read_addr   <= c_first_addr;
                read_enable <= 1'b1;
                r_max       <= '0;
                r_idx       <= '0;
                r_first     <= 1'b1;
                busy        <= 1'b1;
            end else if (r_state == SCAN) begin
                if (w_last_issue) begin
                    read_enable <= 1'b0;
                end else begin
                    read_addr <= read_addr + 10'd1;
                end
            end

            if (w_last_issue) begin
                r_drain_cnt <= c_drain_init;
            end else if ((r_state == DRAIN) && (r_drain_cnt != 2'd0)) begin
                r_drain_cnt <= r_drain_cnt - 2'd1;
            end

            if (w_report) begin
                largest_bucket <= (r_max >= NOISE_FLOOR) ? BUCKET_W'(r_idx) : NO_PEAK;
                peak_mag       <= r_max;
                done           <= 1'b1;
            end

            if ((r_state == IDLE) && done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule : fft_peak_finder
`default_nettype wire
